servo_sweep_ctrl: RTL and testbench
===================================

Name: servo_sweep_ctrl

Overview:
Sweep sequencer directly upstream of servo_pwm: generates the 16-bit angle command (degrees) that replaces the switch-selected angle. On start, it steps the servo from ANGLE_MIN to ANGLE_MAX and waits a settle dwell at each point. At each point it samples the IR sensor level and tracks the strongest reading. It then parks the servo at the peak angle and reports the peak to the core.

Parameters:
ANGLE_MIN, 0, first sweep angle (degrees)
ANGLE_MAX, 180, last permissible sweep angle (degrees)
ANGLE_STEP, 5, increment between sample points (degrees, >0)
DWELL_CYCLES, 2000000, clk cycles of settle time after each angle change
SAMPLE_TIMEOUT, 1000000, clk cycles to wait for ir_valid before substituting level 0
IR_W, 8, IR level width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a sweep
ir_valid  in  1  ir_level is a fresh sample this cycle
ir_level  in  IR_W  IR intensity, unsigned, larger = stronger
angle  out  16  angle command to servo_pwm
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when parked at peak
peak_angle  out  16  angle of strongest reading from the last completed sweep
peak_level  out  IR_W  strongest reading from the last completed sweep

Behaviour:
- Reset values: angle=ANGLE_MIN, busy=0, done=0, peak_angle=ANGLE_MIN, peak_level=0, state=IDLE, counters=0.
- Reset is honoured mid-sweep. It aborts the sweep and restores reset values on the next edge.
- IDLE:
  - start=1 sets angle<=ANGLE_MIN, busy<=1, clears the working peak (level 0, angle ANGLE_MIN), loads the dwell counter, and moves to SETTLE.
  - start while busy is ignored.
- SETTLE: counts DWELL_CYCLES cycles, then moves to SAMPLE. No sampling happens in SETTLE; ir_valid pulses there are discarded.
- SAMPLE:
  - On the first ir_valid, the sample is taken; if none arrives within SAMPLE_TIMEOUT cycles, level 0 is taken instead. Then move to STEP.
  - The working peak updates only when sample > working peak, strictly. Ties keep the earlier (lower) angle.
- STEP:
  - If angle+ANGLE_STEP <= ANGLE_MAX: angle<=angle+ANGLE_STEP, reload dwell, go to SETTLE.
  - Otherwise go to PARK. The sweep never exceeds ANGLE_MAX; the last point is the largest ANGLE_MIN+k*ANGLE_STEP <= ANGLE_MAX.
  - Comparison is done at 17 bits, so there is no wrap.
- PARK:
  - angle<=working peak angle; peak_angle/peak_level are updated from the working registers on entry.
  - Counts DWELL_CYCLES cycles, then done=1 for exactly one cycle, busy<=0, return to IDLE.
- peak_angle/peak_level hold their values between sweeps. They change only on PARK entry or reset.
- A sweep where all samples are 0 parks at ANGLE_MIN with peak_level=0.
- angle changes only in IDLE (on start), STEP and PARK. It is glitch-free and registered.
- Point count is ((ANGLE_MAX-ANGLE_MIN)/ANGLE_STEP)+1. Nominal sweep latency is points*(DWELL_CYCLES+sample wait+2)+DWELL_CYCLES+1 cycles.

Optional Feature:
SWEEP_AVG_EN
- Defined: SAMPLE takes 4 consecutive ir_valid samples per point into an IR_W+2-bit accumulator. The compared value is sum>>2 (truncating). SAMPLE_TIMEOUT applies to the whole 4-sample window; on timeout the samples not yet received count as 0.
- Undefined: single sample per point as above.

Decomposition:
- Shared package holds:
  - state encoding typedef (IDLE, SETTLE, SAMPLE, STEP, PARK)
  - angle width constant 16
  - default dwell/timeout constants
- One natural sub-module: sweep_timer, a loadable down-counter with zero flag, reused for dwell and sample timeout.
- The rest stays in a single FSM.

Test Plan:
- Basic sweep (DWELL_CYCLES=4, ANGLE_STEP=45): ir_level 10,80,30,20,5 at angles 0,45,90,135,180 -> 5 sample points, park angle=45, peak_level=80, one done pulse, busy low afterwards.
- Tie: levels 50,50,10 with ANGLE_MAX=90 -> peak_angle=0 (earlier point wins).
- Non-divisible range (ANGLE_STEP=50, ANGLE_MAX=180) -> points 0,50,100,150 only; angle never >150.
- Timeout (SAMPLE_TIMEOUT=8): no ir_valid at angle 90, others 20 -> point 90 scored 0, sweep completes, peak_level=20.
- Start during busy and ir_valid during SETTLE: start and a level of 255 pulsed while in SETTLE -> both ignored, results unchanged.
- Reset mid-sweep at angle 90 -> next cycle angle=0, busy=0, peak_level=0, no done pulse.

Source files
------------

// File: rtl/servo_sweep_ctrl_pkg.sv
// rtl/servo_sweep_ctrl_pkg.sv - shared types and constants for the servo sweep sequencer
package servo_sweep_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    SAMPLE = 3'd2,
    STEP   = 3'd3,
    PARK   = 3'd4
  } sweep_state_t;

  localparam int ANGLE_W         = 16;
  localparam int TIMER_W         = 32;
  localparam int DEFAULT_DWELL   = 2000000;
  localparam int DEFAULT_TIMEOUT = 1000000;

endpackage

// File: rtl/servo_sweep_ctrl_sweep_timer.sv
// rtl/servo_sweep_ctrl_sweep_timer.sv - loadable down-counter with zero flag, shared by dwell and sample timeout
module sweep_timer
  import servo_sweep_ctrl_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/servo_sweep_ctrl.sv
// rtl/servo_sweep_ctrl.sv - angle sweep sequencer with IR peak tracking; SWEEP_AVG_EN selects 4-sample averaging
module servo_sweep_ctrl
  import servo_sweep_ctrl_pkg::*;
#(
  parameter int ANGLE_MIN      = 0,
  parameter int ANGLE_MAX      = 180,
  parameter int ANGLE_STEP     = 5,
  parameter int DWELL_CYCLES   = DEFAULT_DWELL,
  parameter int SAMPLE_TIMEOUT = DEFAULT_TIMEOUT,
  parameter int IR_W           = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ir_valid,
  input  logic [IR_W-1:0]    ir_level,
  output logic [ANGLE_W-1:0] angle,
  output logic               busy,
  output logic               done,
  output logic [ANGLE_W-1:0] peak_angle,
  output logic [IR_W-1:0]    peak_level
);

  // Timer runs load_value+1 cycles before its zero flag is seen.
  localparam logic [TIMER_W-1:0] DWELL_LOAD   = (DWELL_CYCLES > 0) ? TIMER_W'(DWELL_CYCLES - 1) : '0;
  localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = (SAMPLE_TIMEOUT > 0) ? TIMER_W'(SAMPLE_TIMEOUT - 1) : '0;
  localparam logic [ANGLE_W-1:0] A_MIN  = ANGLE_W'(ANGLE_MIN);
  localparam logic [ANGLE_W:0]   A_MAX  = (ANGLE_W+1)'(ANGLE_MAX);
  localparam logic [ANGLE_W:0]   A_STEP = (ANGLE_W+1)'(ANGLE_STEP);

  sweep_state_t         state, state_next;
  logic                 tmr_load;
  logic [TIMER_W-1:0]   tmr_value;
  logic                 tmr_zero;
  logic [IR_W-1:0]      wk_level;
  logic [ANGLE_W-1:0]   wk_angle;
  logic                 sample_done;
  logic [IR_W-1:0]      sample_value;
  logic [ANGLE_W:0]     angle_inc;
  logic                 step_ok;

  assign angle_inc = {1'b0, angle} + A_STEP;
  assign step_ok   = (angle_inc <= A_MAX);

  sweep_timer #(.W(TIMER_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .load_value (tmr_value),
    .zero       (tmr_zero)
  );

`ifdef SWEEP_AVG_EN
  logic [IR_W+1:0] acc;
  logic [IR_W+1:0] acc_sum;
  logic [1:0]      acc_cnt;

  assign acc_sum = acc + {2'b00, ir_level};

  // Missing samples in a timed-out window contribute 0 to the sum.
  always_comb begin
    sample_done  = (ir_valid && acc_cnt == 2'd3) || tmr_zero;
    sample_value = ir_valid ? acc_sum[IR_W+1:2] : acc[IR_W+1:2];
  end

  always_ff @(posedge clk) begin
    if (rst || state != SAMPLE) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (ir_valid) begin
      acc     <= acc_sum;
      acc_cnt <= acc_cnt + 2'd1;
    end
  end
`else
  always_comb begin
    sample_done  = ir_valid || tmr_zero;
    sample_value = ir_valid ? ir_level : '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_value  = DWELL_LOAD;
    case (state)
      IDLE: if (start) begin
        state_next = SETTLE;
        tmr_load   = 1'b1;
      end
      SETTLE: if (tmr_zero) begin
        state_next = SAMPLE;
        tmr_load   = 1'b1;
        tmr_value  = TIMEOUT_LOAD;
      end
      SAMPLE: if (sample_done) state_next = STEP;
      STEP: begin
        state_next = step_ok ? SETTLE : PARK;
        tmr_load   = 1'b1;
      end
      PARK: if (tmr_zero) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      angle      <= A_MIN;
      busy       <= 1'b0;
      done       <= 1'b0;
      peak_angle <= A_MIN;
      peak_level <= '0;
      wk_angle   <= A_MIN;
      wk_level   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          angle    <= A_MIN;
          busy     <= 1'b1;
          wk_angle <= A_MIN;
          wk_level <= '0;
        end
        // Strict compare: on ties the earlier, lower angle is kept.
        SAMPLE: if (sample_done && sample_value > wk_level) begin
          wk_level <= sample_value;
          wk_angle <= angle;
        end
        STEP: begin
          if (step_ok) begin
            angle <= angle_inc[ANGLE_W-1:0];
          end else begin
            angle      <= wk_angle;
            peak_angle <= wk_angle;
            peak_level <= wk_level;
          end
        end
        PARK: if (tmr_zero) begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_sweep_ctrl.sv
// tb/tb_servo_sweep_ctrl.sv - scoreboard bench for servo_sweep_ctrl with a reactive IR sensor model
module tb_servo_sweep_ctrl;

  localparam int P_MIN   = 0;
  localparam int P_MAX   = 180;
  localparam int P_STEP  = 50;
  localparam int P_DWELL = 4;
  localparam int P_TMO   = 32;
  localparam int P_IRW   = 8;
  localparam int NPTS    = (P_MAX - P_MIN) / P_STEP + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             ir_valid = 1'b0;
  logic [P_IRW-1:0] ir_level = '0;
  logic [15:0]      angle;
  logic             busy;
  logic             done;
  logic [15:0]      peak_angle;
  logic [P_IRW-1:0] peak_level;

  int tests = 0;
  int fails = 0;

  int lvl_tab[NPTS];
  bit dead_tab[NPTS];

  typedef struct {
    int ang;
    int lvl;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  servo_sweep_ctrl #(
    .ANGLE_MIN      (P_MIN),
    .ANGLE_MAX      (P_MAX),
    .ANGLE_STEP     (P_STEP),
    .DWELL_CYCLES   (P_DWELL),
    .SAMPLE_TIMEOUT (P_TMO),
    .IR_W           (P_IRW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ir_valid   (ir_valid),
    .ir_level   (ir_level),
    .angle      (angle),
    .busy       (busy),
    .done       (done),
    .peak_angle (peak_angle),
    .peak_level (peak_level)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk the legal points, score dead ones as 0, keep the first strict maximum.
  function automatic exp_t model_peak();
    exp_t r;
    r.ang = P_MIN;
    r.lvl = 0;
    for (int a = P_MIN; a <= P_MAX; a += P_STEP) begin
      int p;
      int v;
      p = (a - P_MIN) / P_STEP;
      v = dead_tab[p] ? 0 : lvl_tab[p];
      if (v > r.lvl) begin
        r.lvl = v;
        r.ang = a;
      end
    end
    return r;
  endfunction

  task automatic set_tab(input int l0, input int l1, input int l2, input int l3, input int dmask);
    lvl_tab[0] = l0;
    lvl_tab[1] = l1;
    lvl_tab[2] = l2;
    lvl_tab[3] = l3;
    for (int p = 0; p < NPTS; p++) dead_tab[p] = dmask[p];
  endtask

  // Sensor: answers with the level at the current angle; a 255 glitch right after each move must be ignored.
  initial begin
    int          since;
    int          idx;
    logic [15:0] last_ang;
    logic        last_busy;
    since     = 0;
    last_ang  = '0;
    last_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (angle !== last_ang || (busy && !last_busy)) since = 0;
      else if (since < 1000) since++;
      last_ang  = angle;
      last_busy = busy;
      idx = (int'(angle) - P_MIN) / P_STEP;
      if (since < 2) begin
        ir_valid = 1'b1;
        ir_level = 8'hFF;
      end else if (idx >= 0 && idx < NPTS && !dead_tab[idx] && $urandom_range(0, 3) != 0) begin
        ir_valid = 1'b1;
        ir_level = P_IRW'(lvl_tab[idx]);
      end else begin
        ir_valid = 1'b0;
        ir_level = P_IRW'($urandom);
      end
    end
  end

  // Monitor: pops an expectation on every done pulse.
  initial begin
    logic [15:0] last_ang;
    logic        last_done;
    exp_t        e;
    last_ang  = '0;
    last_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (angle !== last_ang)
          check("angle_legal",
                (int'(angle) % P_STEP == 0 && int'(angle) <= P_MAX && int'(angle) >= P_MIN) ? 1 : 0, 1);
        if (done) begin
          check("done_width", int'(last_done), 0);
          if (sb_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("peak_angle", peak_angle, e.ang);
            check("peak_level", peak_level, e.lvl);
            check("park_angle", angle, e.ang);
            check("busy_at_done", busy, 0);
          end
        end
      end
      last_ang  = angle;
      last_done = done;
    end
  end

  task automatic run_sweep(input bit busy_start, input bit do_reset);
    exp_t e;
    int   n;
    e = model_peak();
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    if (busy_start) begin
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    if (do_reset) begin
      n = 0;
      while (int'(angle) != P_MIN + 2 * P_STEP && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check("reach_reset_point", (n < 2000) ? 1 : 0, 1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_angle", angle, P_MIN);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_peak_level", peak_level, 0);
      check("rst_peak_angle", peak_angle, P_MIN);
      rst = 1'b0;
      sb_q.delete();
      repeat (100) @(negedge clk);
      check("idle_after_reset", busy, 0);
    end else begin
      n = 0;
      while (busy && n < 3000) begin
        @(negedge clk);
        n++;
      end
      check("sweep_finished", (n < 3000) ? 1 : 0, 1);
      repeat (3) @(negedge clk);
      check("hold_peak_angle", peak_angle, e.ang);
      check("hold_peak_level", peak_level, e.lvl);
    end
  endtask

  initial begin
    set_tab(0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_angle", angle, P_MIN);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_peak_angle", peak_angle, P_MIN);
    check("reset_peak_level", peak_level, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    set_tab(10, 80, 30, 20, 4'b0000);  run_sweep(1'b0, 1'b0);
    set_tab(50, 50, 10, 0, 4'b0000);   run_sweep(1'b0, 1'b0);
    set_tab(20, 20, 200, 20, 4'b0100); run_sweep(1'b0, 1'b0);
    set_tab(0, 0, 0, 0, 4'b0000);      run_sweep(1'b0, 1'b0);
    set_tab(1, 2, 3, 250, 4'b0000);    run_sweep(1'b0, 1'b0);
    set_tab(40, 90, 60, 10, 4'b0000);  run_sweep(1'b1, 1'b0);
    set_tab(30, 70, 90, 99, 4'b1000);  run_sweep(1'b0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      for (int p = 0; p < NPTS; p++) begin
        lvl_tab[p]  = $urandom_range(0, 255);
        dead_tab[p] = ($urandom_range(0, 4) == 0);
      end
      run_sweep($urandom_range(0, 1) == 1, 1'b0);
    end

    set_tab(10, 80, 30, 20, 4'b0000);  run_sweep(1'b0, 1'b1);
    set_tab(5, 6, 7, 200, 4'b0000);    run_sweep(1'b0, 1'b0);

    repeat (20) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
